seq_pattern_detector: RTL

- Runtime-configurable serial bit-pattern detector.
- Replaces fixed-pattern hard-coded Moore detectors in the serial front end.
- Detects a programmable pattern of 1..MAX_LEN bits on a qualified serial input, in overlapping or non-overlapping mode.
- Raises a registered one-cycle match flag and keeps a saturating match count.

---
 rtl/seq_pattern_detector_pkg.sv | 31 +++
 rtl/seq_match_counter.sv | 27 ++
 rtl/seq_pattern_detector.sv | 114 +++++++++++
 3 files changed

// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector.
//   phase_e           : detector phase (ST_FILL while collecting bits, ST_ARMED once
//                       the next bit can complete a match)
//   DEFAULT_*         : default parameter and reset configuration values
//   clamp_len()       : maps a requested pattern length into the legal range 1..max_len
package seq_pattern_detector_pkg;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } phase_e;

    localparam int unsigned DEFAULT_MAX_LEN = 8;
    localparam int unsigned DEFAULT_LEN_W   = 4;
    localparam int unsigned DEFAULT_CNT_W   = 8;
    localparam logic [7:0]  DEFAULT_PATTERN = 8'b0000_0101;
    localparam int unsigned DEFAULT_LEN     = 3;
    localparam logic        DEFAULT_OVERLAP = 1'b1;

    // Zero-length patterns are meaningless, so they become single-bit patterns.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high
//   clr   : zero the count (wins over inc)
//   inc   : add one, holding at all-ones
//   count : current count
module seq_match_counter
    import seq_pattern_detector_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-configurable serial bit-pattern detector.
//   Clk, Rst         : clock, synchronous active-high reset
//   Cfg_Load         : latch Cfg_Pattern / Cfg_Len / Cfg_Overlap (clears history)
//   Cfg_Pattern      : pattern, bit Len-1 received first, bit 0 last
//   Cfg_Len          : pattern length, clamped to 1..MAX_LEN on load
//   Cfg_Overlap      : 1 = matches may share bits, 0 = restart after each match
//   In_Valid, In     : qualified serial data
//   Clr_Count        : zero Match_Count
//   Out              : registered one-cycle match pulse
//   Match_Count      : saturating match count
//   Armed            : next valid bit can complete a match
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = DEFAULT_MAX_LEN,
    parameter int unsigned          LEN_W       = DEFAULT_LEN_W,
    parameter int unsigned          CNT_W       = DEFAULT_CNT_W,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(DEFAULT_PATTERN),
    parameter int unsigned          DEF_LEN     = DEFAULT_LEN,
    parameter logic                 DEF_OVERLAP = DEFAULT_OVERLAP
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Cfg_Load,
    input  logic [MAX_LEN-1:0] Cfg_Pattern,
    input  logic [LEN_W-1:0]   Cfg_Len,
    input  logic               Cfg_Overlap,
    input  logic               In_Valid,
    input  logic               In,
    input  logic               Clr_Count,
    output logic               Out,
    output logic [CNT_W-1:0]   Match_Count,
    output logic               Armed
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    phase_e             state_q;
    logic               out_q;

    logic [MAX_LEN-1:0] hist_new;
    logic [LEN_W-1:0]   fill_new;
    logic [MAX_LEN-1:0] len_mask;
    logic               cmp_ok;
    logic               shift_en;
    logic               match_now;
    logic               arm_next;

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    assign shift_en  = !Rst && !Cfg_Load && In_Valid;
    assign hist_new  = {hist_q[MAX_LEN-2:0], In};
    assign fill_new  = (fill_q < len_q) ? fill_q + 1'b1 : len_q;
    // Stale bits above Len are masked off so they never affect the compare.
    assign cmp_ok    = ((hist_new ^ pat_q) & len_mask) == '0;
    assign match_now = shift_en && (fill_new == len_q) && cmp_ok;
    // Armed once Len-1 bits are held, i.e. the following bit can finish a match.
    assign arm_next  = (32'(fill_new) + 32'd1) >= 32'(len_q);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pat_q   <= DEF_PATTERN;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= DEF_OVERLAP;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
            out_q   <= 1'b0;
        end else if (Cfg_Load) begin
            pat_q   <= Cfg_Pattern;
            len_q   <= LEN_W'(clamp_len(32'(Cfg_Len), MAX_LEN));
            ovl_q   <= Cfg_Overlap;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
            out_q   <= 1'b0;
        end else if (In_Valid) begin
            hist_q <= hist_new;
            out_q  <= match_now;
            if (match_now && !ovl_q) begin
                // Non-overlapping: consumed bits must not seed the next match.
                fill_q  <= '0;
                state_q <= ST_FILL;
            end else begin
                fill_q  <= fill_new;
                state_q <= arm_next ? ST_ARMED : ST_FILL;
            end
        end else begin
            out_q <= 1'b0;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (Clk),
        .rst   (Rst),
        .clr   (Clr_Count),
        .inc   (match_now),
        .count (Match_Count)
    );

    assign Out   = out_q;
    assign Armed = (state_q == ST_ARMED);

endmodule
